// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP CPU port: FSM states, status-byte
// bit positions, default VRAM address width and the I/O port numbers.
package vdp_pkg;

  localparam int ADDR_W_DEF = 14;

  localparam logic [7:0] PORT_DATA = 8'h98;
  localparam logic [7:0] PORT_CTRL = 8'h99;

  // Status byte layout: {F, 5S, C, fifth[4:0]}
  localparam int STAT_F       = 7;
  localparam int STAT_5S      = 6;
  localparam int STAT_C       = 5;
  localparam int STAT_FIFTH_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_PEND = 2'd1,
    RD_PEND = 2'd2
  } state_t;

endpackage

// File: rtl/vdp_status_reg.sv
// VDP status flags (frame, fifth sprite, collision, fifth sprite number)
// with clear-on-read semantics and the registered active-low interrupt.
module vdp_status_reg
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_set,
  input  logic       coll_set,
  input  logic       fifth_set,
  input  logic [4:0] fifth_num,
  input  logic       irq_en,
  input  logic       status_rd,
  output logic [7:0] status,
  output logic       n_int
);

  logic       f_reg;
  logic       s5_reg;
  logic       c_reg;
  logic [4:0] fifth_reg;
  logic       n_int_reg;

  // A set pulse wins over the clear of a coinciding read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_reg     <= 1'b0;
      s5_reg    <= 1'b0;
      c_reg     <= 1'b0;
      fifth_reg <= '0;
      n_int_reg <= 1'b1;
    end else begin
      f_reg  <= frame_set | (f_reg & ~status_rd);
      c_reg  <= coll_set | (c_reg & ~status_rd);
      s5_reg <= fifth_set | (s5_reg & ~status_rd);
      if (fifth_set && !s5_reg) begin
        fifth_reg <= fifth_num;
      end
      n_int_reg <= ~(f_reg & irq_en);
    end
  end

  always_comb begin
    status                       = '0;
    status[STAT_F]               = f_reg;
    status[STAT_5S]              = s5_reg;
    status[STAT_C]               = c_reg;
    status[STAT_FIFTH_W-1:0]     = fifth_reg;
  end

  assign n_int = n_int_reg;

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU side of the VDP: ports 0x98/0x99, address/register setup, VRAM
// request FSM with read-ahead buffer. VDP_CPU_WAIT_EN stalls the CPU while busy.
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_wr,
  input  logic              data_rd,
  input  logic              ctrl_wr,
  input  logic              ctrl_rd,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rdata,
  output logic              reg_we,
  output logic [2:0]        reg_num,
  output logic [7:0]        reg_data,
  input  logic              frame_set,
  input  logic              coll_set,
  input  logic              fifth_set,
  input  logic [4:0]        fifth_num,
  input  logic              irq_en,
  output logic              n_int,
  output logic              wait_n,
  output logic              overrun
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        first_reg;
  logic [7:0]        buffer_reg;
  logic [7:0]        dout_reg;
  logic [7:0]        wdata_reg;
  logic              toggle_reg;
  logic              overrun_reg;
  logic              reg_we_reg;
  logic [2:0]        reg_num_reg;
  logic [7:0]        reg_data_reg;
  logic [7:0]        status;
  logic              idle;
  logic              launch_ra;

  assign idle      = (state_reg == IDLE);
  // Second control byte with bit7=0 and bit6=0 requests a read-ahead.
  assign launch_ra = ctrl_wr & toggle_reg & ~din[7] & ~din[6];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (data_wr) begin
          state_next = WR_PEND;
        end else if (data_rd || launch_ra) begin
          state_next = RD_PEND;
        end
      end
      WR_PEND, RD_PEND: begin
        if (vram_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      first_reg    <= '0;
      buffer_reg   <= '0;
      dout_reg     <= '0;
      wdata_reg    <= '0;
      toggle_reg   <= 1'b0;
      overrun_reg  <= 1'b0;
      reg_we_reg   <= 1'b0;
      reg_num_reg  <= '0;
      reg_data_reg <= '0;
    end else begin
      state_reg  <= state_next;
      reg_we_reg <= 1'b0;
      if (!idle && vram_ack) begin
        addr_reg <= addr_reg + ADDR_W'(1);
        if (state_reg == RD_PEND) begin
          buffer_reg <= vram_rdata;
        end
      end
      if (idle) begin
        if (data_wr) begin
          wdata_reg  <= din;
          toggle_reg <= 1'b0;
        end
        if (data_rd) begin
          dout_reg   <= buffer_reg;
          toggle_reg <= 1'b0;
        end
        if (ctrl_rd) begin
          dout_reg   <= status;
          toggle_reg <= 1'b0;
        end
        if (ctrl_wr) begin
          if (!toggle_reg) begin
            first_reg  <= din;
            toggle_reg <= 1'b1;
          end else begin
            toggle_reg <= 1'b0;
            if (din[7]) begin
              if (int'(din[5:0]) < NREGS) begin
                reg_we_reg   <= 1'b1;
                reg_num_reg  <= din[2:0];
                reg_data_reg <= first_reg;
              end
            end else begin
              addr_reg <= ADDR_W'({din[5:0], first_reg});
            end
          end
        end
      end
`ifndef VDP_CPU_WAIT_EN
      else if (data_wr || data_rd || ctrl_wr || ctrl_rd) begin
        overrun_reg <= 1'b1;
      end
`endif
    end
  end

  vdp_status_reg u_status (
    .clk       (clk),
    .reset     (reset),
    .frame_set (frame_set),
    .coll_set  (coll_set),
    .fifth_set (fifth_set),
    .fifth_num (fifth_num),
    .irq_en    (irq_en),
    .status_rd (ctrl_rd & idle),
    .status    (status),
    .n_int     (n_int)
  );

  assign dout       = dout_reg;
  assign vram_req   = ~idle;
  assign vram_we    = (state_reg == WR_PEND);
  assign vram_addr  = addr_reg;
  assign vram_wdata = wdata_reg;
  assign reg_we     = reg_we_reg;
  assign reg_num    = reg_num_reg;
  assign reg_data   = reg_data_reg;
  assign overrun    = overrun_reg;

`ifdef VDP_CPU_WAIT_EN
  assign wait_n = idle;
`else
  assign wait_n = 1'b1;
`endif

endmodule
